fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: 2-deep {inst,pc} queue fed by a 1-cycle-latency imem; 2 cycles request->InstValid, 1 inst/cycle steady.
// Backpressure: IdReady=0 stalls pops and fetch is throttled so queue + in-flight never exceed two; Redirect flushes.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemRdata,
    input  logic        Redirect,
    input  logic [31:0] RedirectPc,
    input  logic        IdReady,
    output logic        InstValid,
    output logic [31:0] Inst,
    output logic [31:0] PcOut
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic [31:0] pc_hold;
    logic        inflight;
    logic        squash;

    entry_t      fifo_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    logic        pop;
    logic        push;
    logic        issue;
    logic        pop_acct;
    logic [2:0]  demand;
    entry_t      head;

    assign head      = fifo_mem[rd_ptr];
    assign InstValid = (count != 2'd0);
    assign Inst      = InstValid ? head.inst : NOP_INST;
    assign PcOut     = InstValid ? head.pc   : pc_hold;
    assign ImemAddr  = fetch_pc;

    // Slots already committed (queued or in flight) minus the one leaving this cycle.
    assign pop    = InstValid & IdReady;
    assign demand = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue  = rst_n & ~Redirect & (demand < 3'd2);
    assign ImemReq = issue;

    assign push     = inflight & ~squash & ~Redirect;
    assign pop_acct = pop & ~Redirect;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{inst: ImemRdata, pc: req_pc};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            req_pc   <= 32'h0;
            pc_hold  <= 32'h0;
            inflight <= 1'b0;
            squash   <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            inflight <= issue;
            squash   <= Redirect & issue;
            pc_hold  <= PcOut;
            if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (Redirect) begin
                fetch_pc <= {RedirectPc[31:2], 2'b00};
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
                count    <= 2'd0;
            end else begin
                if (push) begin
                    wr_ptr <= ~wr_ptr;
                end
                if (pop_acct) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count + {1'b0, push} - {1'b0, pop_acct};
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: startup, stall, redirects, PC wrap and mid-run reset.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc_out;

    logic        rst_n_b;
    logic        req_b;
    logic [31:0] addr_b;
    logic [31:0] rdata_b = 32'h0;
    logic        redirect_b = 1'b0;
    logic [31:0] redirect_pc_b = 32'h0;
    logic        id_ready_b = 1'b1;
    logic        valid_b;
    logic [31:0] inst_b;
    logic [31:0] pc_b;

    int checks = 0;
    int errors = 0;

    fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n),
        .ImemReq(imem_req), .ImemAddr(imem_addr), .ImemRdata(imem_rdata),
        .Redirect(redirect), .RedirectPc(redirect_pc), .IdReady(id_ready),
        .InstValid(inst_valid), .Inst(inst), .PcOut(pc_out)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst_n(rst_n_b),
        .ImemReq(req_b), .ImemAddr(addr_b), .ImemRdata(rdata_b),
        .Redirect(redirect_b), .RedirectPc(redirect_pc_b), .IdReady(id_ready_b),
        .InstValid(valid_b), .Inst(inst_b), .PcOut(pc_b)
    );

    // Memory models: request seen mid-cycle, data returned just after the next edge.
    logic        mem_req_a, mem_req_b;
    logic [31:0] mem_addr_a, mem_addr_b;

    always @(negedge clk) begin
        mem_req_a  = imem_req;
        mem_addr_a = imem_addr;
        @(posedge clk);
        #1;
        imem_rdata = mem_req_a ? (mem_addr_a ^ KEY) : 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        mem_req_b  = req_b;
        mem_addr_b = addr_b;
        @(posedge clk);
        #1;
        rdata_b = mem_req_b ? (mem_addr_b ^ KEY) : 32'hDEAD_BEEF;
    end

    logic [31:0] log_pc_b   [3];
    logic [31:0] log_inst_b [3];
    int          nb = 0;

    always @(negedge clk) begin
        if (rst_n_b === 1'b1 && valid_b === 1'b1) begin
            if (nb < 3) begin
                log_pc_b[nb]   = pc_b;
                log_inst_b[nb] = inst_b;
            end
            nb = nb + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        rst_n_b     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b1;

        repeat (2) @(posedge clk);
        mid();
        check_eq("rst_req",   imem_req,   0);
        check_eq("rst_valid", inst_valid, 0);
        check_eq("rst_inst",  inst,       NOP);
        check_eq("rst_pc",    pc_out,     0);

        // Startup with IdReady=1
        cyc_start(); rst_n = 1'b1; rst_n_b = 1'b1;
        mid();
        check_eq("c0_req",  imem_req,  1);
        check_eq("c0_addr", imem_addr, 32'h0);
        cyc_start(); mid();
        check_eq("c1_addr",  imem_addr,  32'h4);
        check_eq("c1_valid", inst_valid, 0);
        cyc_start(); mid();
        check_eq("c2_valid", inst_valid, 1);
        check_eq("c2_pc",    pc_out,     32'h0);
        check_eq("c2_inst",  inst,       KEY);
        cyc_start(); mid();
        check_eq("c3_pc",   pc_out, 32'h4);
        check_eq("c3_inst", inst,   32'h4 ^ KEY);
        cyc_start(); mid();
        check_eq("c4_pc", pc_out, 32'h8);

        // Stall from cycle 2, then release
        cyc_start(); rst_n = 1'b0;
        cyc_start(); rst_n = 1'b1;
        mid();
        cyc_start(); mid();
        cyc_start(); id_ready = 1'b0;
        mid();
        check_eq("st2_pc", pc_out, 32'h0);
        cyc_start(); mid();
        check_eq("st3_req",   imem_req,   0);
        check_eq("st3_valid", inst_valid, 1);
        check_eq("st3_pc",    pc_out,     32'h0);
        cyc_start(); mid();
        check_eq("st4_req", imem_req, 0);
        check_eq("st4_pc",  pc_out,   32'h0);
        cyc_start(); id_ready = 1'b1;
        mid();
        check_eq("st5_pc",   pc_out,    32'h0);
        check_eq("st5_req",  imem_req,  1);
        check_eq("st5_addr", imem_addr, 32'h8);
        cyc_start(); mid();
        check_eq("st6_pc", pc_out, 32'h4);
        cyc_start(); mid();
        check_eq("st7_pc",   pc_out, 32'h8);
        check_eq("st7_inst", inst,   32'h8 ^ KEY);

        // Fill queue to two, then reset asynchronously mid-cycle
        cyc_start(); id_ready = 1'b0;
        mid();
        cyc_start(); mid();
        check_eq("full_valid", inst_valid, 1);
        check_eq("full_req",   imem_req,   0);
        #2; rst_n = 1'b0;
        #1;
        check_eq("arst_valid", inst_valid, 0);
        check_eq("arst_inst",  inst,       NOP);
        check_eq("arst_req",   imem_req,   0);
        check_eq("arst_pc",    pc_out,     32'h0);
        cyc_start(); rst_n = 1'b1; id_ready = 1'b1;
        mid();
        check_eq("rs0_req",  imem_req,  1);
        check_eq("rs0_addr", imem_addr, 32'h0);
        cyc_start(); mid();
        cyc_start(); mid();
        check_eq("rs2_valid", inst_valid, 1);
        check_eq("rs2_pc",    pc_out,     32'h0);

        // Redirect with a response in flight
        cyc_start(); redirect = 1'b1; redirect_pc = 32'h0000_0103;
        mid();
        check_eq("rd_req",   imem_req,   0);
        check_eq("rd_valid", inst_valid, 1);
        cyc_start(); redirect = 1'b0;
        mid();
        check_eq("rd1_req",   imem_req,   1);
        check_eq("rd1_addr",  imem_addr,  32'h100);
        check_eq("rd1_valid", inst_valid, 0);
        cyc_start(); mid();
        check_eq("rd2_valid", inst_valid, 0);
        cyc_start(); mid();
        check_eq("rd3_valid", inst_valid, 1);
        check_eq("rd3_pc",    pc_out,     32'h100);
        check_eq("rd3_inst",  inst,       32'h100 ^ KEY);
        cyc_start(); mid();
        check_eq("rd4_pc", pc_out, 32'h104);

        // Back-to-back redirects: last wins
        cyc_start(); redirect = 1'b1; redirect_pc = 32'h200;
        mid();
        cyc_start(); redirect_pc = 32'h300;
        mid();
        check_eq("bb1_req",   imem_req,   0);
        check_eq("bb1_valid", inst_valid, 0);
        cyc_start(); redirect = 1'b0;
        mid();
        check_eq("bb2_req",  imem_req,  1);
        check_eq("bb2_addr", imem_addr, 32'h300);
        cyc_start(); mid();
        check_eq("bb3_valid", inst_valid, 0);
        cyc_start(); mid();
        check_eq("bb4_valid", inst_valid, 1);
        check_eq("bb4_pc",    pc_out,     32'h300);

        // PC wrap on the second instance
        check_eq("wrap_cnt", (nb >= 3) ? 32'd1 : 32'd0, 32'd1);
        if (nb >= 3) begin
            check_eq("wrap_pc0",   log_pc_b[0],   32'hFFFF_FFF8);
            check_eq("wrap_pc1",   log_pc_b[1],   32'hFFFF_FFFC);
            check_eq("wrap_pc2",   log_pc_b[2],   32'h0000_0000);
            check_eq("wrap_inst2", log_inst_b[2], KEY);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
